// File: rtl/operand_addr_gen_pkg.sv
// Shared types and helpers for the operand address generator.
package operand_addr_gen_pkg;

  typedef enum logic [1:0] {
    DT_FP16 = 2'd0,
    DT_INT8 = 2'd1,
    DT_INT4 = 2'd2
  } datatype_e;

  typedef struct packed {
    datatype_e  datatype;
    logic [1:0] rc;
  } addrgen_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int STEP_HALF = 2;
  localparam int STEP_WORD = 4;

  // Halfword beats for FP16 and for INT8 in the two narrow rc shapes; word beats otherwise.
  function automatic logic [2:0] step_bytes(input addrgen_t t);
    if (t.datatype == DT_FP16 ||
        (t.datatype == DT_INT8 && (t.rc == 2'b01 || t.rc == 2'b10)))
      return 3'(STEP_HALF);
    else
      return 3'(STEP_WORD);
  endfunction

  // rc=11 has no meaning for any of the defined datatypes.
  function automatic logic is_illegal(input addrgen_t t);
    return (t.rc == 2'b11) &&
           (t.datatype == DT_FP16 || t.datatype == DT_INT8 || t.datatype == DT_INT4);
  endfunction

endpackage

// File: rtl/operand_addr_gen_sweep_counter.sv
// Row / k beat counters for one sweep, with last-beat flags and the
// commit flag for the beat that follows the current one.
module operand_addr_gen_sweep_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_k_beats,
  input  logic [CNT_W-1:0] i_n_rows,
  output logic             o_k_last,
  output logic             o_last,
  output logic             o_next_cmen
);

  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_kb;
  logic [CNT_W-1:0] r_nr;
  logic             w_row_last;

  assign o_k_last   = (r_k == r_kb - CNT_W'(1));
  assign w_row_last = (r_row == r_nr - CNT_W'(1));
  assign o_last     = o_k_last && w_row_last;
  // After the last beat of a row the next beat is k=0, which commits only for 1-beat rows.
  assign o_next_cmen = o_k_last ? (r_kb == CNT_W'(1))
                                : (r_k + CNT_W'(1) == r_kb - CNT_W'(1));

  // Counters track the beat currently presented on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k   <= '0;
      r_row <= '0;
      r_kb  <= '0;
      r_nr  <= '0;
    end else if (i_load) begin
      r_k   <= '0;
      r_row <= '0;
      r_kb  <= i_k_beats;
      r_nr  <= i_n_rows;
    end else if (i_adv) begin
      if (o_k_last) begin
        r_k   <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_k <= r_k + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/operand_addr_gen.sv
// Issue stage for one operand skew chain: turns a tile-sweep descriptor into
// a per-cycle rdaddr/en/cmen stream for lane 0, with addrtype held per sweep.
module operand_addr_gen
  import operand_addr_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [CNT_W-1:0]  k_beats,
  input  logic [CNT_W-1:0]  n_rows,
  input  addrgen_t          addrtype_in,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              en,
  output logic              cmen,
  output addrgen_t          addrtype
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_reject;
  logic              w_adv;
  logic              w_k_last;
  logic              w_last;
  logic              w_next_cmen;
  logic [ADDR_W-1:0] w_step_in;
  logic [ADDR_W-1:0] w_row_next;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [ADDR_W-1:0] r_row_ptr;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_step;
  logic              r_en;
  logic              r_cmen;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  addrgen_t          r_addrtype;

  assign w_step_in  = ADDR_W'(step_bytes(addrtype_in));
  assign w_row_next = r_row_ptr + r_stride;

  operand_addr_gen_sweep_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_adv      (w_adv),
    .i_k_beats  (k_beats),
    .i_n_rows   (n_rows),
    .o_k_last   (w_k_last),
    .o_last     (w_last),
    .o_next_cmen(w_next_cmen)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle issue decisions; the last beat ends the sweep even if stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (is_illegal(addrtype_in)) begin
            w_reject = 1'b1;
          end else if (k_beats == '0 || n_rows == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_last)      w_state_nxt = S_DONE;
        else if (!stall) w_adv = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and incremental address: reload from row_ptr at each row start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_cmen     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdaddr   <= '0;
      r_row_ptr  <= '0;
      r_stride   <= '0;
      r_step     <= '0;
      r_addrtype <= '0;
    end else begin
      r_en   <= w_accept || w_adv;
      r_cmen <= w_accept ? (k_beats == CNT_W'(1)) : (w_adv && w_next_cmen);
      r_busy <= (w_state_nxt == S_ISSUE);
      r_done <= (w_state_nxt == S_DONE);
      r_err  <= w_reject;
      if (w_accept) begin
        r_rdaddr   <= base_addr;
        r_row_ptr  <= base_addr;
        r_stride   <= row_stride;
        r_step     <= w_step_in;
        r_addrtype <= addrtype_in;
      end else if (w_adv) begin
        if (w_k_last) begin
          r_rdaddr  <= w_row_next;
          r_row_ptr <= w_row_next;
        end else begin
          r_rdaddr <= r_rdaddr + r_step;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rdaddr   = r_rdaddr;
  assign en       = r_en;
  assign cmen     = r_cmen;
  assign addrtype = r_addrtype;

endmodule

// File: tb/tb_operand_addr_gen.sv
// Scoreboard bench for operand_addr_gen: descriptors are expanded into expected
// beat lists by a plain-arithmetic model; a negedge monitor checks the stream.
module tb_operand_addr_gen;
  import operand_addr_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] row_stride = '0;
  logic [7:0]  k_beats = '0;
  logic [7:0]  n_rows = '0;
  addrgen_t    addrtype_in = '0;
  logic        stall = 1'b0;
  logic        busy, done, err, en, cmen;
  logic [31:0] rdaddr;
  addrgen_t    addrtype;

  operand_addr_gen #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .k_beats(k_beats), .n_rows(n_rows),
    .addrtype_in(addrtype_in), .stall(stall), .busy(busy), .done(done),
    .err(err), .rdaddr(rdaddr), .en(en), .cmen(cmen), .addrtype(addrtype)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        cmen;
  } beat_t;

  beat_t    beat_q[$];
  int       pending_done = 0;
  int       pending_err = 0;
  addrgen_t exp_at = '0;
  int       n_vec = 0;
  int       n_bad = 0;
  bit       was_busy = 0;
  bit       exp_done_next = 0;
  logic     stall_s = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  function automatic int step_of(input addrgen_t t);
    if (t.datatype == DT_FP16) return 2;
    if (t.datatype == DT_INT8 && (t.rc == 2'b01 || t.rc == 2'b10)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] b, input logic [31:0] s,
                                          input int r, input int k, input int st);
    return b + 32'(r) * s + 32'(k * st);
  endfunction

  // Stall as seen by the DUT at the active edge.
  always @(posedge clk) stall_s = stall;

  // Monitor: pop and compare every presented beat; check done/err/busy coherence.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      was_busy      = 0;
      exp_done_next = 0;
    end else begin
      if (exp_done_next) begin
        chk("done_after_last_beat", done, 1'b1);
        exp_done_next = 0;
      end
      if (en) begin
        if (beat_q.size() == 0) begin
          flag("spurious_en");
        end else begin
          b = beat_q.pop_front();
          chk("rdaddr", rdaddr, b.addr);
          chk("cmen", cmen, b.cmen);
          chk("addrtype_issue", addrtype, exp_at);
          chk("busy_issue", busy, 1'b1);
          if (was_busy && stall_s) flag("en_during_stall");
          if (beat_q.size() == 0) exp_done_next = 1;
        end
      end else begin
        if (cmen) flag("cmen_without_en");
        if (was_busy && !stall_s && beat_q.size() > 0) flag("issue_bubble");
      end
      if (done) begin
        if (pending_done == 0) flag("spurious_done");
        else begin
          pending_done--;
          chk("beats_left_at_done", beat_q.size(), 0);
          chk("busy_at_done", busy, 1'b0);
        end
      end
      if (err) begin
        if (pending_err == 0) flag("spurious_err");
        else pending_err--;
      end
      if (busy && !en && beat_q.size() == 0) flag("busy_without_work");
      was_busy = busy;
    end
  end

  task automatic run(input logic [31:0] b, input logic [31:0] s, input logic [7:0] kb,
                     input logic [7:0] nr, input addrgen_t at, input int stall_pct,
                     input int stall_beg);
    int c;
    bit ill, zero;
    int st;
    logic [31:0] held;
    c = 0;
    while ((busy || done) && c < 50) begin
      @(negedge clk);
      c++;
    end
    ill  = (at.rc == 2'b11) &&
           (at.datatype == DT_FP16 || at.datatype == DT_INT8 || at.datatype == DT_INT4);
    zero = (kb == 0) || (nr == 0);
    st   = step_of(at);
    held = '0;
    if (ill) pending_err++;
    else if (zero) pending_done++;
    else begin
      for (int r = 0; r < int'(nr); r++)
        for (int k = 0; k < int'(kb); k++)
          beat_q.push_back('{addr: addr_of(b, s, r, k, st), cmen: (k == int'(kb) - 1)});
      pending_done++;
      exp_at = at;
      if (stall_beg > 0)
        held = addr_of(b, s, (stall_beg - 1) / int'(kb), (stall_beg - 1) % int'(kb), st);
    end
    start = 1'b1; base_addr = b; row_stride = s; k_beats = kb; n_rows = nr; addrtype_in = at;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom; row_stride = $urandom; k_beats = 8'($urandom);
    n_rows = 8'($urandom); addrtype_in = addrgen_t'({2'($urandom_range(2)), 2'($urandom)});
    if (ill) begin
      chk("err_pulse", err, 1'b1);
      chk("busy_on_err", busy, 1'b0);
      chk("en_on_err", en, 1'b0);
      return;
    end
    if (zero) begin
      chk("zero_done_pulse", done, 1'b1);
      chk("zero_no_en", en, 1'b0);
      return;
    end
    chk("first_en_latency", en, 1'b1);
    c = 0;
    while (!done && c < 600) begin
      if (stall_beg > 0) stall = (c == stall_beg - 1) || (c == stall_beg);
      else stall = ($urandom_range(99) < stall_pct);
      if ($urandom_range(7) == 0) begin
        start = 1'b1; base_addr = $urandom; k_beats = 8'($urandom_range(1, 4));
        n_rows = 8'($urandom_range(1, 3));
      end else start = 1'b0;
      @(negedge clk);
      c++;
      if (stall_beg > 0 && (c == stall_beg || c == stall_beg + 1)) begin
        chk("en_low_in_stall", en, 1'b0);
        chk("rdaddr_held_in_stall", rdaddr, held);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (!done) flag("sweep_timeout");
  endtask

  function automatic addrgen_t mk(input datatype_e dt, input logic [1:0] rc);
    addrgen_t t;
    t.datatype = dt;
    t.rc = rc;
    return t;
  endfunction

  initial begin
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_cmen", cmen, 1'b0);
    chk("rst_rdaddr", rdaddr, 32'h0);
    chk("rst_addrtype", addrtype, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(32'h100, 32'h40, 8'd4, 8'd2, mk(DT_FP16, 2'b00), 0, -1);
    run(32'h0, 32'h20, 8'd3, 8'd1, mk(DT_INT8, 2'b00), 0, -1);
    repeat (3) @(negedge clk);
    chk("addrtype_held_after_done", addrtype, mk(DT_INT8, 2'b00));
    run(32'h1000, 32'h80, 8'd3, 8'd2, mk(DT_INT4, 2'b10), 0, 2);
    run(32'h40, 32'h10, 8'd0, 8'd3, mk(DT_INT8, 2'b00), 0, -1);
    run(32'h40, 32'h10, 8'd2, 8'd0, mk(DT_FP16, 2'b01), 0, -1);
    run(32'h40, 32'h10, 8'd2, 8'd2, mk(DT_INT8, 2'b11), 0, -1);
    @(negedge clk);
    chk("addrtype_kept_after_err", addrtype, mk(DT_INT4, 2'b10));
    run(32'hFFFF_FFFC, 32'h100, 8'd3, 8'd1, mk(DT_INT8, 2'b00), 0, -1);

    // Abort an 8-beat sweep during its third beat.
    while (busy || done) @(negedge clk);
    for (int k = 0; k < 8; k++) beat_q.push_back('{addr: 32'h200 + 32'(2 * k), cmen: (k == 7)});
    pending_done++;
    exp_at = mk(DT_FP16, 2'b00);
    start = 1'b1; base_addr = 32'h200; row_stride = 32'h0; k_beats = 8'd8; n_rows = 8'd1;
    addrtype_in = mk(DT_FP16, 2'b00);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_en", en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rdaddr", rdaddr, 32'h0);
    chk("abort_done", done, 1'b0);
    beat_q.delete();
    pending_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run(32'h300, 32'h30, 8'd2, 8'd2, mk(DT_INT8, 2'b01), 0, -1);

    for (int i = 0; i < 25; i++)
      run($urandom, 32'($urandom_range(0, 32'h400)), 8'($urandom_range(0, 6)),
          8'($urandom_range(0, 4)), mk(datatype_e'($urandom_range(2)), 2'($urandom)), 30, -1);

    repeat (4) @(negedge clk);
    chk("final_beats_pending", beat_q.size(), 0);
    chk("final_done_pending", pending_done, 0);
    chk("final_err_pending", pending_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
